// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_tx_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned IDX_W       = $clog2(UART_DATA_W);
    localparam int unsigned NBITS_W     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } t_uart_tx_state;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } t_parity_mode;

    typedef struct packed {
        logic [NBITS_W-1:0] nbits;
        t_parity_mode       parity;
        logic               stop2;
    } t_frame_fmt;

    // Mode 3 is reserved and behaves as no parity.
    function automatic t_parity_mode decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    // Build a frame format from the raw configuration inputs.
    function automatic t_frame_fmt decode_fmt(input logic [1:0] data_bits,
                                              input logic [1:0] parity_mode,
                                              input logic       stop2);
        t_frame_fmt fmt;
        fmt.nbits  = NBITS_W'(5) + NBITS_W'(data_bits);
        fmt.parity = decode_parity(parity_mode);
        fmt.stop2  = stop2;
        return fmt;
    endfunction

    // Parity over the low nbits of the byte; odd parity is the inverted XOR.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                        input t_frame_fmt             fmt);
        logic p;
        p = 1'b0;
        for (int i = 0; i < int'(UART_DATA_W); i++) begin
            if (i < int'(fmt.nbits)) begin
                p = p ^ data[i];
            end
        end
        return (fmt.parity == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_framer_cfg_fifo.sv
// First-word-fall-through synchronous FIFO with registered ready and count.
module fifo_sync_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data_c,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             wr_fire_c;
    logic             rd_fire_c;

    // A full FIFO never accepts, even when a read frees a slot this cycle.
    assign wr_fire_c    = wr_en && ready;
    assign rd_fire_c    = rd_en && (count != '0);
    assign count_next_c = count + CW'(wr_fire_c) - CW'(rd_fire_c);
    assign rd_data_c    = mem[rd_ptr_q];

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            ready    <= 1'b1;
        end else begin
            if (wr_fire_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_fire_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count <= count_next_c;
            ready <= (count_next_c < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_framer_cfg.sv
// UART transmitter with runtime frame format (5-8 data bits, parity, 1/2 stop bits).
module uart_tx_framer_cfg
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DATA_MAX   = 8
) (
    input  logic                        i_clk_7_37mhz,
    input  logic                        i_rstn_7_37mhz,
    input  logic [DATA_MAX-1:0]         i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic                        o_tx_drop,
    input  logic [1:0]                  i_data_bits,
    input  logic [1:0]                  i_parity_mode,
    input  logic                        i_stop2,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_busy,
    output logic                        eo_uart_tx
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);

    t_uart_tx_state                state_q;
    t_uart_tx_state                state_n;
    logic [CNT_W-1:0]              baud_cnt_q;
    logic                          tick_c;
    logic [UART_DATA_W-1:0]        byte_q;
    logic [UART_DATA_W-1:0]        byte_n;
    t_frame_fmt                    fmt_q;
    t_frame_fmt                    fmt_n;
    logic [IDX_W-1:0]              idx_q;
    logic [IDX_W-1:0]              idx_n;
    logic                          pop_c;
    logic                          line_c;
    logic                          last_bit_c;
    logic                          parity_c;
    logic                          fifo_nonempty_c;
    logic                          fifo_ready;
    logic [DATA_MAX-1:0]           fifo_head_c;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count_next_c;

    // Transmit queue between the byte producer and the framer.
    fifo_sync_fwft #(
        .WIDTH (DATA_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (i_clk_7_37mhz),
        .rst_n        (i_rstn_7_37mhz),
        .wr_en        (i_tx_valid),
        .wr_data      (i_tx_data),
        .rd_en        (pop_c),
        .rd_data_c    (fifo_head_c),
        .ready        (fifo_ready),
        .count        (fifo_count),
        .count_next_c (fifo_count_next_c)
    );

    assign o_tx_ready      = fifo_ready;
    assign o_fifo_count    = fifo_count;
    assign fifo_nonempty_c = (fifo_count != '0);
    assign tick_c          = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
    assign last_bit_c      = (NBITS_W'(idx_q) == (fmt_q.nbits - NBITS_W'(1)));
    assign parity_c        = parity_bit(byte_q, fmt_q);

    // Bit-period counter; parked at zero in IDLE so the start bit is a full period.
    always_ff @(posedge i_clk_7_37mhz or negedge i_rstn_7_37mhz) begin
        if (!i_rstn_7_37mhz) begin
            baud_cnt_q <= '0;
        end else if (state_q == IDLE || tick_c) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
        end
    end

    // Frame state and per-frame latched byte, format and bit index.
    always_ff @(posedge i_clk_7_37mhz or negedge i_rstn_7_37mhz) begin
        if (!i_rstn_7_37mhz) begin
            state_q <= IDLE;
            byte_q  <= '0;
            fmt_q   <= decode_fmt(2'd3, 2'd0, 1'b0);
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            byte_q  <= byte_n;
            fmt_q   <= fmt_n;
            idx_q   <= idx_n;
        end
    end

    // Next-state, FIFO pop and line level; pops latch byte and format together.
    always_comb begin
        state_n = state_q;
        byte_n  = byte_q;
        fmt_n   = fmt_q;
        idx_n   = idx_q;
        pop_c   = 1'b0;
        line_c  = 1'b1;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty_c) begin
                    state_n = START;
                    pop_c   = 1'b1;
                end
            end
            START: begin
                line_c = 1'b0;
                if (tick_c) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                line_c = byte_q[idx_q];
                if (tick_c) begin
                    if (last_bit_c) begin
                        state_n = (fmt_q.parity == PAR_NONE) ? STOP1 : PARITY;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                line_c = parity_c;
                if (tick_c) begin
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (tick_c) begin
                    if (fmt_q.stop2) begin
                        state_n = STOP2;
                    end else if (fifo_nonempty_c) begin
                        state_n = START;
                        pop_c   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            STOP2: begin
                if (tick_c) begin
                    if (fifo_nonempty_c) begin
                        state_n = START;
                        pop_c   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (pop_c) begin
            byte_n = UART_DATA_W'(fifo_head_c);
            fmt_n  = decode_fmt(i_data_bits, i_parity_mode, i_stop2);
        end
    end

    // Registered outputs: serial line, drop pulse and busy flag.
    always_ff @(posedge i_clk_7_37mhz or negedge i_rstn_7_37mhz) begin
        if (!i_rstn_7_37mhz) begin
            eo_uart_tx <= 1'b1;
            o_tx_drop  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            eo_uart_tx <= line_c;
            o_tx_drop  <= i_tx_valid && !fifo_ready;
            o_busy     <= (state_n != IDLE) || (fifo_count_next_c != '0);
        end
    end

endmodule
